dct_2d_pass_ctrl: RTL
=====================

// Module: dct_2d_pass_ctrl
// PURPOSE
//   Sequences one shared dct_1d_8x8 instance through both passes of an 8x8 2D DCT:
//   row pass, transpose, column pass, transpose back.
//   Accepts one flattened 8x8 block per valid/ready handshake and returns the 2D result
//   on a second valid/ready handshake.
//   Sits between the block fetch stage and the quantiser. Coefficients are wired to the
//   DCT instance outside this block.
// PARAMETERS
//   DATA_WIDTH  32  element width, Q16.16 signed, matches dct_1d_8x8
//   DCT_LAT     2   cycles from a stable dct_data_in to a valid dct_out (0 = combinational)
//   CNT_W       16  width of blocks_done counter
// PORTS
//   clk          in   1         clock, all logic on rising edge
//   reset        in   1         synchronous, active-high reset
//   in_valid     in   1         in_block holds a new block
//   in_ready     out  1         controller can accept a block
//   in_block     in   64*DW     element (r,c) at bits [(r*8+c)*DW +: DW]
//   dct_data_in  out  64*DW     operand driven to dct_1d_8x8.data_in
//   dct_out      in   64*DW     result from dct_1d_8x8.dct_out
//   out_valid    out  1         out_block holds a finished 2D DCT
//   out_ready    in   1         downstream accepts out_block
//   out_block    out  64*DW     2D DCT result, same element layout as in_block
//   busy         out  1         high in ROW, COL or DONE
//   pass_col     out  1         1 while the column pass is running (debug)
//   blocks_done  out  CNT_W     count of completed output handshakes, wraps at 2^CNT_W
// BEHAVIOUR
//   Storage and counters
//   - One 64*DW register buf; dct_data_in = buf and out_block = buf (no extra copy).
//   - Transpose T(X): element (c,r) of T(X) = element (r,c) of X. Bit-exact; no arithmetic
//     and no rounding in this block.
//   - Pass counter cnt is $clog2(DCT_LAT+1) bits wide, minimum 1 bit.
//   FSM states: IDLE, ROW, COL, DONE
//   - IDLE: in_ready = 1.
//     On in_valid: buf <= in_block, cnt <= 0, go to ROW.
//   - ROW: buf is held, so dct_data_in is stable for the whole pass.
//     cnt increments each cycle. When cnt == DCT_LAT: buf <= T(dct_out), cnt <= 0, go to COL.
//   - COL: same rules as ROW. When cnt == DCT_LAT: buf <= T(dct_out), go to DONE.
//   - DONE: out_valid = 1, buf is held.
//     On out_ready: blocks_done increments, go to IDLE.
//   Latency
//   - out_valid rises exactly 2*DCT_LAT+2 cycles after the accepting edge.
//   - With out_ready held high, throughput is one block per 2*DCT_LAT+4 cycles.
//     That is accept, passes, output handshake, then IDLE for 1 cycle.
//   Handshake rules
//   - in_ready = 1 only in IDLE. Asserting in_valid in any other state has no effect, and
//     the block is not captured.
//   - out_valid stays high and out_block stays stable until out_ready is sampled high.
//   - out_ready while out_valid = 0 is ignored.
//   - in_ready and out_valid are never high in the same cycle. The next block is accepted
//     no earlier than the cycle after the output handshake.
//   Reset (sampled on the clock edge; applies mid-pass)
//   - FSM returns to IDLE, cnt = 0, buf = 0, blocks_done = 0.
//   - Outputs: in_ready = 1, out_valid = 0, busy = 0, pass_col = 0, and
//     dct_data_in = out_block = 0 after the edge.
//   - Any in-flight block is discarded; no partial output is produced.
//   - Reset has priority over every handshake in the same cycle.
//   Other outputs
//   - busy = (state != IDLE). pass_col = (state == COL).
// TESTING
//   1. Identity stub (dct_out = dct_data_in after DCT_LAT=2 regs); in_block elements 0..63
//      -> out_block == in_block (double transpose); out_valid 6 cycles after the accept edge.
//   2. Real dct_1d_8x8 with DCT_LAT matching it; in_block all 0x00010000 (1.0)
//      -> out[0] = 0x00080000 (8.0); all other elements within 0x00008000 of 0.
//   3. out_ready low for 10 cycles after out_valid
//      -> out_block stable and in_ready = 0 throughout; blocks_done +1 only on the handshake.
//   4. in_valid held high with two blocks queued; swap in_block during ROW
//      -> second block accepted only after the first output handshake; output 1 is unaffected.
//   5. reset pulsed during COL (cnt=1) -> next cycle IDLE, in_ready=1, out_valid=0, blocks_done=0;
//      a fresh block then completes normally.
//   6. DCT_LAT=0 back-to-back, 4 blocks, out_ready tied high -> one block per 4 cycles;
//      blocks_done = 4.

Source files
------------

// File: rtl/dct_2d_pass_ctrl_if.sv
// Block-level streaming ports of the 2D DCT pass controller: one flattened 8x8 block in, one out.
// Both sides are strict valid/ready: a transfer happens on a rising edge where valid && ready; the source holds valid and data stable until then, and ready never depends combinationally on valid.
interface dct_2d_pass_ctrl_if #(
  parameter int DW = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [64*DW-1:0] in_block;
  logic            out_valid;
  logic            out_ready;
  logic [64*DW-1:0] out_block;

  // master: block source and result sink (fetch stage / quantiser side)
  modport master (
    output in_valid, in_block, out_ready,
    input  in_ready, out_valid, out_block
  );

  // slave: the pass controller itself
  modport slave (
    input  in_valid, in_block, out_ready,
    output in_ready, out_valid, out_block
  );
endinterface

// File: rtl/dct_2d_pass_ctrl.sv
// Runs one shared 1D 8x8 DCT twice (rows, then columns) with a transpose after each pass,
// holding the working block in a single register that feeds both the DCT and the output.
module dct_2d_pass_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DCT_LAT    = 2,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  dct_2d_pass_ctrl_if.slave          blk_if,
  output logic [64*DATA_WIDTH-1:0]   dct_data_in,
  input  logic [64*DATA_WIDTH-1:0]   dct_out,
  output logic                       busy,
  output logic                       pass_col,
  output logic [CNT_W-1:0]           blocks_done
);
  localparam int BW = 64 * DATA_WIDTH;
  localparam int CW = (DCT_LAT < 1) ? 1 : $clog2(DCT_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DCT_LAT);

  typedef enum logic [1:0] {IDLE, ROW, COL, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    blk_q, blk_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [BW-1:0]    dct_out_t;

  // Pure rewiring: element (r,c) of dct_out lands at (c,r).
  always_comb begin
    dct_out_t = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        dct_out_t[(c*8+r)*DATA_WIDTH +: DATA_WIDTH] = dct_out[(r*8+c)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    blk_d            = blk_q;
    done_d           = done_q;
    blk_if.in_ready  = 1'b0;
    blk_if.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        blk_if.in_ready = 1'b1;
        if (blk_if.in_valid) begin
          blk_d   = blk_if.in_block;
          cnt_d   = '0;
          state_d = ROW;
        end
      end
      ROW, COL: begin
        // The operand register stays put, so dct_out is valid once DCT_LAT cycles have passed.
        if (cnt_q == CNT_LAST) begin
          blk_d   = dct_out_t;
          cnt_d   = '0;
          state_d = (state_q == ROW) ? COL : DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        blk_if.out_valid = 1'b1;
        if (blk_if.out_ready) begin
          done_d  = done_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      done_q  <= done_d;
    end
  end

  assign dct_data_in      = blk_q;
  assign blk_if.out_block = blk_q;
  assign busy             = (state_q != IDLE);
  assign pass_col         = (state_q == COL);
  assign blocks_done      = done_q;
endmodule
